// File: rtl/hqm_aw_clk_req_ctl_pkg.sv
// hqm_AW_pkg
//   Shared types and helpers for the clock-request controller.
//   hqm_AW_clk_req_state_t : gated-clock FSM states (OFF, WAKE, ON, HYST).
//   cnt_width()           : counter width for a down-counter loaded with n-1,
//                           never narrower than one bit.
package hqm_AW_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_HYST = 2'd3
    } hqm_AW_clk_req_state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hqm_aw_clk_req_ctl.sv
// hqm_aw_clk_req_ctl
//   Clock-request controller for a shared gated clock. Requesters raise a
//   level request; the clock is enabled, allowed to settle for WAKE_CYC
//   cycles, and then each active requester is acknowledged. After the last
//   request drops the clock stays on for cfg_hyst cycles before gating off.
//
// Ports
//   clk          : free-running clock, rising edge
//   rst_n        : synchronous active-low reset
//   req          : [NUM_REQ] level request per requester
//   cfg_hyst     : [HYST_W] hysteresis cycles after the last request drops
//   cfg_force_on : keep the clock running regardless of requests
//   clk_en       : registered enable for the downstream clock gate
//   ack          : [NUM_REQ] registered per-requester grant (clock stable)
//   idle         : registered, high while the FSM is OFF
module hqm_aw_clk_req_ctl
    import hqm_AW_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned WAKE_CYC = 4,
    parameter int unsigned HYST_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [HYST_W-1:0]  cfg_hyst,
    input  logic               cfg_force_on,
    output logic               clk_en,
    output logic [NUM_REQ-1:0] ack,
    output logic               idle
);

    localparam int unsigned         WCW       = cnt_width(WAKE_CYC);
    localparam logic [WCW-1:0]      WAKE_LOAD = WCW'(WAKE_CYC - 1);

    hqm_AW_clk_req_state_t state_q;
    logic [WCW-1:0]        wake_cnt_q;
    logic [HYST_W-1:0]     hyst_cnt_q;
    logic                  clk_en_q;
    logic                  idle_q;
    logic [NUM_REQ-1:0]    ack_q;
    logic                  want_clk;

    assign want_clk = (|req) | cfg_force_on;

    // clk_en/idle are updated alongside every state change so they stay
    // flop outputs that track the state they are registered with.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            wake_cnt_q <= '0;
            hyst_cnt_q <= '0;
            clk_en_q   <= 1'b0;
            idle_q     <= 1'b1;
            ack_q      <= '0;
        end else begin
            ack_q <= (state_q == ST_ON) ? req : '0;

            case (state_q)
                ST_OFF: begin
                    if (want_clk) begin
                        state_q    <= ST_WAKE;
                        wake_cnt_q <= WAKE_LOAD;
                        clk_en_q   <= 1'b1;
                        idle_q     <= 1'b0;
                    end
                end

                // Settling period always completes, even if requests vanish.
                ST_WAKE: begin
                    if (wake_cnt_q == '0) begin
                        state_q <= ST_ON;
                    end else begin
                        wake_cnt_q <= wake_cnt_q - 1'b1;
                    end
                end

                ST_ON: begin
                    if (!want_clk) begin
                        if (cfg_hyst != '0) begin
                            state_q    <= ST_HYST;
                            hyst_cnt_q <= cfg_hyst - 1'b1;
                        end else begin
                            state_q  <= ST_OFF;
                            clk_en_q <= 1'b0;
                            idle_q   <= 1'b1;
                        end
                    end
                end

                // Clock is still stable here, so a new request skips WAKE.
                ST_HYST: begin
                    if (want_clk) begin
                        state_q <= ST_ON;
                    end else if (hyst_cnt_q == '0) begin
                        state_q  <= ST_OFF;
                        clk_en_q <= 1'b0;
                        idle_q   <= 1'b1;
                    end else begin
                        hyst_cnt_q <= hyst_cnt_q - 1'b1;
                    end
                end

                default: begin
                    state_q  <= ST_OFF;
                    clk_en_q <= 1'b0;
                    idle_q   <= 1'b1;
                end
            endcase
        end
    end

    assign clk_en = clk_en_q;
    assign ack    = ack_q;
    assign idle   = idle_q;

endmodule

// File: tb/tb_hqm_aw_clk_req_ctl.sv
// tb_hqm_aw_clk_req_ctl
//   Directed scenarios followed by randomized request traffic, each cycle
//   compared against a behavioural model of the clock-request rules.
module tb_hqm_aw_clk_req_ctl;

    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned WAKE_CYC = 4;
    localparam int unsigned HYST_W   = 8;

    logic               clk;
    logic               rst_n;
    logic [NUM_REQ-1:0] req;
    logic [HYST_W-1:0]  cfg_hyst;
    logic               cfg_force_on;
    logic               clk_en;
    logic [NUM_REQ-1:0] ack;
    logic               idle;

    int n_checks;
    int n_fail;

    // Behavioural model: clock on/off plus remaining wake / hysteresis cycles.
    bit                 m_clk_on;
    int                 m_wake_rem;
    int                 m_hyst_rem;
    logic [NUM_REQ-1:0] m_ack;

    hqm_aw_clk_req_ctl #(
        .NUM_REQ (NUM_REQ),
        .WAKE_CYC(WAKE_CYC),
        .HYST_W  (HYST_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .cfg_hyst    (cfg_hyst),
        .cfg_force_on(cfg_force_on),
        .clk_en      (clk_en),
        .ack         (ack),
        .idle        (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model across one edge using the current inputs, then clock
    // the DUT and compare all outputs.
    task automatic cyc();
        bit want;
        bit running;
        if (!rst_n) begin
            m_clk_on   = 1'b0;
            m_wake_rem = 0;
            m_hyst_rem = 0;
            m_ack      = '0;
        end else begin
            want    = (req != '0) || cfg_force_on;
            running = m_clk_on && (m_wake_rem == 0) && (m_hyst_rem == 0);
            m_ack   = running ? req : '0;
            if (!m_clk_on) begin
                if (want) begin
                    m_clk_on   = 1'b1;
                    m_wake_rem = WAKE_CYC;
                end
            end else if (m_wake_rem > 0) begin
                m_wake_rem--;
            end else if (m_hyst_rem > 0) begin
                if (want) begin
                    m_hyst_rem = 0;
                end else begin
                    m_hyst_rem--;
                    if (m_hyst_rem == 0) m_clk_on = 1'b0;
                end
            end else if (!want) begin
                if (cfg_hyst == '0) m_clk_on = 1'b0;
                else                m_hyst_rem = int'(cfg_hyst);
            end
        end
        @(posedge clk);
        #1;
        check_eq("clk_en", 32'(clk_en), 32'(m_clk_on));
        check_eq("idle",   32'(idle),   32'(!m_clk_on));
        check_eq("ack",    32'(ack),    32'(m_ack));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int lat;
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        req          = '0;
        cfg_hyst     = 8'd3;
        cfg_force_on = 1'b0;
        m_clk_on     = 1'b0;
        m_wake_rem   = 0;
        m_hyst_rem   = 0;
        m_ack        = '0;

        @(posedge clk);
        #1;
        run(2);
        rst_n = 1'b1;
        run(2);

        // First grant latency from OFF.
        req = 4'b0001;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (k == 1) check_eq("wake_clk_en_c1", 32'(clk_en), 32'd1);
            if (ack != '0 && lat == 0) lat = k;
        end
        check_eq("ack_latency", 32'(lat), 32'(WAKE_CYC + 2));

        // Add a requester while ON, then drop everything into a 3-cycle HYST.
        req = 4'b0011;
        run(3);
        req = 4'b0000;
        run(6);

        // Re-request during HYST with one count left: no wake period.
        req = 4'b0001;
        run(8);
        req = 4'b0000;
        run(2);
        req = 4'b0100;
        run(4);
        req = 4'b0000;

        // Zero hysteresis: straight to OFF; then force-on with no requests.
        cfg_hyst = 8'd0;
        run(3);
        cfg_force_on = 1'b1;
        run(10);
        check_eq("force_on_ack", 32'(ack), 32'd0);
        cfg_force_on = 1'b0;
        run(3);

        // One-cycle request pulse in OFF still runs the full wake.
        cfg_hyst = 8'd2;
        req = 4'b0010;
        run(1);
        req = 4'b0000;
        run(10);

        // Reset while ON.
        req = 4'b1000;
        run(9);
        rst_n = 1'b0;
        run(1);
        check_eq("reset_idle", 32'(idle), 32'd1);
        rst_n = 1'b1;
        req = 4'b0000;
        run(2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < NUM_REQ; b++)
                if ($urandom_range(7) == 0) req[b] = ~req[b];
            if ($urandom_range(31) == 0) cfg_force_on = ~cfg_force_on;
            if ($urandom_range(15) == 0) cfg_hyst = HYST_W'($urandom_range(5));
            rst_n = ($urandom_range(199) != 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hqm_aw_clk_req_ctl.md
HQM_AW_CLK_REQ_CTL -- requirements
Module: hqm_AW_clk_req_ctl

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the gated clock.
REQ-002 Parameter WAKE_CYC, default 4: cycles the clock runs before grant (clock settle); legal range >= 1.
REQ-003 Parameter HYST_W, default 8: width of hysteresis count.
REQ-004 clk  input  1: free-running clock; all flops on rising edge.
REQ-005 rst_n  input  1: reset, synchronous, active-low.
REQ-006 req  input  NUM_REQ: level request per requester, held until ack then until done.
REQ-007 cfg_hyst  input  HYST_W: cycles clock stays on after last request drops.
REQ-008 cfg_force_on  input  1: keep clock on regardless of requests.
REQ-009 clk_en  output  1: enable to downstream clock gate/buffer, registered.
REQ-010 ack  output  NUM_REQ: per-requester grant (clock stable), registered.
REQ-011 idle  output  1: high when state is OFF.

Function
REQ-012 FSM states SHALL be OFF, WAKE, ON, HYST; clk_en SHALL be 1 in WAKE, ON and HYST, and 0 in OFF.
REQ-013 OFF: |req or cfg_force_on SHALL go to WAKE and load wake_cnt = WAKE_CYC-1.
REQ-014 WAKE: wake_cnt SHALL decrement each cycle; at wake_cnt==0 SHALL go to ON.
REQ-015 WAKE SHALL run to completion even if all req drop (no abort); ON then evaluates normally.
REQ-016 ack[i] SHALL register req[i] while state==ON, else 0; first ack is WAKE_CYC+2 cycles after req seen in OFF.
REQ-017 ON: a new req[j] while ON SHALL get ack[j] the next cycle; a dropped req[i] SHALL clear ack[i] the next cycle.
REQ-018 ON with no req and no cfg_force_on: cfg_hyst!=0 SHALL go to HYST and load hyst_cnt=cfg_hyst-1; cfg_hyst==0 SHALL go directly to OFF.
REQ-019 HYST: any req or cfg_force_on SHALL return to ON without a wake period; otherwise hyst_cnt decrements, at 0 SHALL go to OFF.
REQ-020 ack SHALL be 0 in OFF, WAKE and HYST.
REQ-021 cfg_hyst changes SHALL take effect only on the next ON->HYST load; cfg_force_on is sampled every cycle.
REQ-022 Counters SHALL NOT wrap: wake_cnt width $clog2(WAKE_CYC) min 1, hyst_cnt width HYST_W, decrement gated at 0.

Reset
REQ-023 On rst_n==0 at a clock edge: state=OFF, clk_en=0, ack=0, idle=1, counters=0, including mid-WAKE/ON/HYST.
REQ-024 First cycle after reset release SHALL evaluate OFF transitions normally.

Structure
REQ-025 State enum typedef hqm_AW_clk_req_state_t SHALL reside in hqm_AW_pkg, imported by the module.
REQ-026 Block is flat; no sub-module; the clock gate and hqm_AW_clkbuf driven by clk_en are instanced by the parent.
REQ-027 All outputs SHALL be flop outputs; no combinational input-to-output path.

Verification
REQ-028 Defaults, req=4'b0001 at cycle 0 from OFF -> clk_en=1 at cycle 1, ack=4'b0001 at cycle 6, idle=0 at cycle 1.
REQ-029 In ON, req 0001->0011 -> ack=0011 next cycle; req drops to 0000, cfg_hyst=3 -> ack=0 next cycle, HYST 3 cycles, clk_en=0 and idle=1 after.
REQ-030 HYST with hyst_cnt=1, req=4'b0100 -> back to ON, ack=0100 next cycle after ON, no wake delay, clk_en never drops.
REQ-031 cfg_hyst=0, last req drops in ON -> OFF next cycle, clk_en=0; cfg_force_on=1 with req=0 -> WAKE, ON, stays ON with ack=0.
REQ-032 req pulses 1 cycle in OFF -> full 4-cycle WAKE, ON one cycle, ack stays 0, then HYST/OFF; rst_n=0 during ON -> all outputs reset next edge.
